accel_job_scheduler: RTL and testbench

Batch sequencer for the single-shot accelerator wrapper, which is the memory-streaming kernel shell around the HLS kernel. It accepts one batch descriptor of N tile jobs. For each job it programs the wrapper's read/write base addresses and sizes, then releases the wrapper from reset so the job runs. It waits for the wrapper's done pulse, advances the bases by a fixed stride and re-arms the wrapper for the next job. It sits between the host/config bus and the wrapper, adds a per-job watchdog and abort, and reports batch status and cycle count.

---
 rtl/accel_job_scheduler.sv | 115 +++++++++++
 tb/tb_accel_job_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_job_scheduler.sv
// accel_job_scheduler: runs a batch of tile jobs through the single-shot accelerator wrapper, with watchdog and abort.
module accel_job_scheduler #(
    parameter int ADDR_W     = 64,
    parameter int JOB_W      = 16,
    parameter int TO_W       = 32,
    parameter int RST_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_read_base,
    input  logic [ADDR_W-1:0] cfg_write_base,
    input  logic [ADDR_W-1:0] cfg_stride,
    input  logic [ADDR_W-1:0] cfg_num_read,
    input  logic [ADDR_W-1:0] cfg_elem_size,
    input  logic [JOB_W-1:0]  cfg_num_jobs,
    input  logic [TO_W-1:0]   cfg_timeout,
    input  logic              abort,
    output logic              acc_rst,
    output logic [ADDR_W-1:0] acc_read_base,
    output logic [ADDR_W-1:0] acc_write_base,
    output logic [ADDR_W-1:0] acc_num_read,
    output logic [ADDR_W-1:0] acc_read_size,
    input  logic              acc_done,
    output logic              busy,
    output logic [JOB_W-1:0]  job_idx,
    output logic [JOB_W-1:0]  jobs_done,
    output logic              batch_done,
    output logic [1:0]        status,
    output logic [TO_W-1:0]   batch_cycles
);
    localparam int RC_W = $clog2(RST_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, RST, RUN} state_t;
    state_t state, state_nx;
    logic [RC_W-1:0] rst_cnt;
    logic [TO_W-1:0] wd_cnt, timeout;
    logic [JOB_W-1:0] num_jobs;
    logic [ADDR_W-1:0] stride;
    logic last_job, wd_hit, rst_end, job_fin;

    assign cfg_ready = state == IDLE;
    assign busy = state != IDLE;
    assign acc_rst = reset || state != RUN;
    assign last_job = jobs_done + 1'b1 == num_jobs;
    assign rst_end = rst_cnt == RC_W'(RST_CYCLES - 1);
    assign wd_hit = timeout != '0 && wd_cnt == timeout - 1'b1;
    assign job_fin = state == RUN && acc_done && !abort;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = cfg_valid && cfg_num_jobs != '0 ? RST : IDLE;
            RST:     state_nx = abort ? IDLE : rst_end ? RUN : RST;
            RUN:     state_nx = abort ? IDLE : acc_done ? (last_job ? IDLE : RST) : wd_hit ? IDLE : RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rst_cnt <= '0;
            wd_cnt <= '0;
            timeout <= '0;
            num_jobs <= '0;
            stride <= '0;
            acc_read_base <= '0;
            acc_write_base <= '0;
            acc_num_read <= '0;
            acc_read_size <= '0;
            job_idx <= '0;
            jobs_done <= '0;
            batch_done <= 1'b0;
            status <= 2'd0;
            batch_cycles <= '0;
        end else begin
            state <= state_nx;
            batch_done <= 1'b0;
            if (state == IDLE) begin
                if (cfg_valid) begin
                    acc_read_base <= cfg_read_base;
                    acc_write_base <= cfg_write_base;
                    acc_num_read <= cfg_num_read;
                    acc_read_size <= cfg_elem_size;
                    stride <= cfg_stride;
                    num_jobs <= cfg_num_jobs;
                    timeout <= cfg_timeout;
                    job_idx <= '0;
                    jobs_done <= '0;
                    status <= 2'd0;
                    rst_cnt <= '0;
                    batch_cycles <= TO_W'(1);
                    batch_done <= cfg_num_jobs == '0;
                end
            end else begin
                batch_cycles <= &batch_cycles ? batch_cycles : batch_cycles + 1'b1;
                rst_cnt <= state == RST ? rst_cnt + 1'b1 : '0;
                wd_cnt <= state == RUN ? wd_cnt + 1'b1 : '0;
                if (state_nx == IDLE) begin
                    batch_done <= 1'b1;
                    status <= abort ? 2'd2 : state == RUN && acc_done ? 2'd0 : 2'd1;
                end
                if (job_fin) begin
                    jobs_done <= jobs_done + 1'b1;
                    if (!last_job) begin
                        job_idx <= job_idx + 1'b1;
                        acc_read_base <= acc_read_base + stride;
                        acc_write_base <= acc_write_base + stride;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_accel_job_scheduler.sv
// tb_accel_job_scheduler: directed and randomized batches checked every cycle against a job-timeline model.
module tb_accel_job_scheduler;
    localparam int AW = 64;
    localparam int JW = 16;
    localparam int TW = 32;
    localparam int RC = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic cfg_valid = 1'b0;
    logic cfg_ready;
    logic [AW-1:0] cfg_read_base = '0, cfg_write_base = '0, cfg_stride = '0, cfg_num_read = '0, cfg_elem_size = '0;
    logic [JW-1:0] cfg_num_jobs = '0;
    logic [TW-1:0] cfg_timeout = '0;
    logic abort = 1'b0;
    logic acc_rst;
    logic [AW-1:0] acc_read_base, acc_write_base, acc_num_read, acc_read_size;
    logic auto_done = 1'b0, man_done = 1'b0;
    logic acc_done;
    logic busy, batch_done;
    logic [JW-1:0] job_idx, jobs_done;
    logic [1:0] status;
    logic [TW-1:0] batch_cycles;

    int n_chk = 0, n_fail = 0;
    int lat = 0;
    bit rand_lat = 1'b0;
    int run_cnt = 0;

    assign acc_done = auto_done | man_done;

    accel_job_scheduler #(.ADDR_W(AW), .JOB_W(JW), .TO_W(TW), .RST_CYCLES(RC)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_read_base(cfg_read_base), .cfg_write_base(cfg_write_base), .cfg_stride(cfg_stride),
        .cfg_num_read(cfg_num_read), .cfg_elem_size(cfg_elem_size), .cfg_num_jobs(cfg_num_jobs),
        .cfg_timeout(cfg_timeout), .abort(abort), .acc_rst(acc_rst), .acc_read_base(acc_read_base),
        .acc_write_base(acc_write_base), .acc_num_read(acc_num_read), .acc_read_size(acc_read_size),
        .acc_done(acc_done), .busy(busy), .job_idx(job_idx), .jobs_done(jobs_done),
        .batch_done(batch_done), .status(status), .batch_cycles(batch_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a batch is a timeline of jobs, each RC reset cycles followed by run cycles.
    bit m_act, m_bd;
    int m_k;
    logic [JW-1:0] m_job, m_done, m_num;
    logic [TW-1:0] m_to, m_cyc;
    logic [1:0] m_st;
    logic [AW-1:0] m_rb0, m_wb0, m_stride, m_nr, m_es;

    task automatic m_reset();
        m_act = 0; m_bd = 0; m_k = 0; m_job = '0; m_done = '0; m_num = '0; m_to = '0; m_cyc = '0;
        m_st = '0; m_rb0 = '0; m_wb0 = '0; m_stride = '0; m_nr = '0; m_es = '0;
    endtask

    task automatic m_finish(input logic [1:0] s);
        m_act = 0;
        m_bd = 1;
        m_st = s;
    endtask

    task automatic m_step();
        m_bd = 0;
        if (!m_act) begin
            if (cfg_valid) begin
                m_rb0 = cfg_read_base; m_wb0 = cfg_write_base; m_stride = cfg_stride;
                m_nr = cfg_num_read; m_es = cfg_elem_size; m_num = cfg_num_jobs; m_to = cfg_timeout;
                m_job = '0; m_done = '0; m_cyc = TW'(1); m_st = 2'd0;
                if (cfg_num_jobs == '0) m_bd = 1;
                else begin
                    m_act = 1;
                    m_k = 1;
                end
            end
        end else begin
            if (m_cyc != '1) m_cyc = m_cyc + 1'b1;
            if (abort) m_finish(2'd2);
            else if (m_k > RC && acc_done) begin
                m_done = m_done + 1'b1;
                if (m_done == m_num) m_finish(2'd0);
                else begin
                    m_job = m_job + 1'b1;
                    m_k = 1;
                end
            end else if (m_k > RC && m_to != '0 && longint'(m_k - RC) == longint'(m_to)) m_finish(2'd1);
            else m_k++;
        end
    endtask

    always @(negedge clk) begin
        if (reset) m_reset();
        chk("acc_rst", acc_rst, !m_act || m_k <= RC);
        chk("cfg_ready", cfg_ready, !m_act);
        chk("busy", busy, m_act);
        chk("job_idx", job_idx, m_job);
        chk("jobs_done", jobs_done, m_done);
        chk("batch_done", batch_done, m_bd);
        chk("status", status, m_st);
        chk("batch_cycles", batch_cycles, m_cyc);
        chk("acc_read_base", acc_read_base, m_rb0 + AW'(m_job) * m_stride);
        chk("acc_write_base", acc_write_base, m_wb0 + AW'(m_job) * m_stride);
        chk("acc_num_read", acc_num_read, m_nr);
        chk("acc_read_size", acc_read_size, m_es);
        if (!reset) m_step();
    end

    // Wrapper stand-in: pulses done after lat run cycles; in random mode also emits spurious pulses while held.
    always @(posedge clk) begin
        #1;
        if (reset || acc_rst) begin
            run_cnt = 0;
            if (rand_lat) lat = $urandom_range(1, 12);
            auto_done = rand_lat && ($urandom_range(0, 3) == 0);
        end else begin
            auto_done = lat != 0 && run_cnt == lat - 1;
            run_cnt++;
        end
    end

    logic [AW-1:0] rel_rb[$], rel_wb[$];
    int gaps[$], lows[$];
    bit last_low;

    task automatic start(input logic [AW-1:0] rb, input logic [AW-1:0] wb, input logic [AW-1:0] st,
                         input int n, input int to);
        cfg_read_base = rb; cfg_write_base = wb; cfg_stride = st;
        cfg_num_read = AW'(256); cfg_elem_size = AW'(4);
        cfg_num_jobs = JW'(n); cfg_timeout = TW'(to);
        cfg_valid = 1;
        cyc();
        cfg_valid = 0;
    endtask

    task automatic run_batch();
        int hi = 0, lo = 0, k = 0;
        bit started = 0;
        rel_rb.delete(); rel_wb.delete(); gaps.delete(); lows.delete();
        last_low = 0;
        while (!batch_done && k < 3000) begin
            if (acc_rst) begin
                if (lo > 0) begin lows.push_back(lo); lo = 0; end
                hi++;
            end else begin
                if (hi > 0) begin
                    if (started) gaps.push_back(hi);
                    started = 1;
                    rel_rb.push_back(acc_read_base);
                    rel_wb.push_back(acc_write_base);
                    hi = 0;
                end
                lo++;
            end
            last_low = !acc_rst;
            cyc();
            k++;
        end
        if (lo > 0) lows.push_back(lo);
        chk("batch_done_reached", batch_done, 1);
    endtask

    task automatic wait_release();
        int k = 0;
        while (acc_rst && k < 100) begin cyc(); k++; end
        chk("release_reached", acc_rst, 0);
    endtask

    initial begin
        logic [AW-1:0] exp_rb[3];
        int k;
        #1 reset = 1;
        repeat (3) cyc();
        chk("reset_acc_rst", acc_rst, 1);
        chk("reset_cfg_ready", cfg_ready, 1);
        reset = 0;
        cyc();

        lat = 50;
        start(64'h1000, 64'h8000, 64'h0, 1, 0);
        run_batch();
        chk("t1_low_cycles", lows.size() == 1 ? lows[0] : -1, 50);
        chk("t1_low_then_bdone", last_low, 1);
        chk("t1_status", status, 0);
        chk("t1_jobs_done", jobs_done, 1);
        chk("t1_batch_cycles", batch_cycles, RC + 51);
        cyc();
        chk("t1_bdone_once", batch_done, 0);

        lat = 8;
        start(64'h1000, 64'h8000, 64'h400, 3, 0);
        run_batch();
        exp_rb = '{64'h1000, 64'h1400, 64'h1800};
        chk("t2_releases", rel_rb.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("t2_read_base", i < rel_rb.size() ? rel_rb[i] : '1, exp_rb[i]);
            chk("t2_write_base", i < rel_wb.size() ? rel_wb[i] : '1, exp_rb[i] + 64'h7000);
        end
        chk("t2_gap_count", gaps.size(), 2);
        foreach (gaps[i]) chk("t2_gap_len", gaps[i], RC);
        chk("t2_jobs_done", jobs_done, 3);
        chk("t2_status", status, 0);

        lat = 0;
        start(64'h3000, 64'h9000, 64'h40, 2, 20);
        run_batch();
        chk("t3_low_cycles", lows.size() == 1 ? lows[0] : -1, 20);
        chk("t3_status", status, 1);
        chk("t3_jobs_done", jobs_done, 0);
        cyc();
        chk("t3_bdone_once", batch_done, 0);

        start(64'h1000, 64'h8000, 64'h400, 4, 0);
        wait_release();
        repeat (3) cyc();
        man_done = 1;
        cyc();
        man_done = 0;
        wait_release();
        chk("t4_job1_base", acc_read_base, 64'h1400);
        repeat (2) cyc();
        abort = 1;
        man_done = 1;
        cyc();
        abort = 0;
        man_done = 0;
        chk("t4_status", status, 2);
        chk("t4_jobs_done", jobs_done, 1);
        chk("t4_busy", busy, 0);
        chk("t4_cfg_ready", cfg_ready, 1);
        chk("t4_batch_done", batch_done, 1);
        chk("t4_acc_rst", acc_rst, 1);

        lat = 3;
        start(64'h4000, 64'h4800, 64'h10, 0, 0);
        chk("t5_zero_bdone", batch_done, 1);
        chk("t5_zero_busy", busy, 0);
        chk("t5_zero_batch_cycles", batch_cycles, 1);
        for (int i = 0; i < 4; i++) begin
            chk("t5_zero_acc_rst", acc_rst, 1);
            cyc();
        end
        start(64'h5000, 64'h6000, 64'h10, 3, 0);
        k = 0;
        while (!(jobs_done == 1 && !acc_rst) && k < 200) begin cyc(); k++; end
        chk("t5_mid_run", jobs_done, 1);
        reset = 1;
        #1;
        chk("t5_rst_acc_rst", acc_rst, 1);
        chk("t5_rst_jobs_done", jobs_done, 0);
        chk("t5_rst_job_idx", job_idx, 0);
        chk("t5_rst_batch_cycles", batch_cycles, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_read_base", acc_read_base, 0);
        repeat (2) cyc();
        reset = 0;
        cyc();

        lat = 4;
        cfg_read_base = 64'h2000; cfg_write_base = 64'hA000; cfg_stride = 64'h100;
        cfg_num_jobs = JW'(2); cfg_timeout = '0;
        cfg_valid = 1;
        cyc();
        run_batch();
        chk("t6_jobs_done", jobs_done, 2);
        chk("t6_second_base", rel_rb.size() == 2 ? rel_rb[1] : '1, 64'h2100);
        chk("t6_ready_at_bdone", cfg_ready, 1);
        cyc();
        chk("t6_reaccept_busy", busy, 1);
        chk("t6_restart_read_base", acc_read_base, 64'h2000);
        chk("t6_restart_write_base", acc_write_base, 64'hA000);
        chk("t6_restart_batch_cycles", batch_cycles, 1);
        cfg_valid = 0;
        run_batch();
        chk("t6_second_jobs_done", jobs_done, 2);

        rand_lat = 1;
        for (int b = 0; b < 40; b++) begin
            cfg_read_base = {$urandom, $urandom};
            cfg_write_base = {$urandom, $urandom};
            cfg_stride = {$urandom, $urandom};
            cfg_num_read = AW'($urandom);
            cfg_elem_size = AW'($urandom_range(1, 8));
            cfg_num_jobs = JW'($urandom_range(0, 5));
            cfg_timeout = $urandom_range(0, 2) == 0 ? TW'($urandom_range(1, 15)) : '0;
            abort = $urandom_range(0, 3) == 0;
            cfg_valid = 1;
            cyc();
            cfg_valid = 0;
            abort = 0;
            k = 0;
            while (busy && k < 3000) begin
                abort = $urandom_range(0, 50) == 0;
                cfg_valid = $urandom_range(0, 5) == 0;
                cfg_read_base = {$urandom, $urandom};
                cyc();
                k++;
            end
            abort = 0;
            cfg_valid = 0;
            chk("rand_batch_end", busy, 0);
            cyc();
        end
        rand_lat = 0;
        repeat (2) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
